// File: rtl/ff_async_reset.sv
`default_nettype none
// ============================================================================
// Module   : ff_async_reset
// Brief    : W-bit D register, asynchronous active-high reset, loads every edge.
// Revision : 1.0 - initial release
// ============================================================================

module ff_async_reset #(
    parameter int            W         = 1,
    parameter logic [W-1:0]  RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Reset sits in the sensitivity list so it wins over a coincident clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: tb/tb_ff_async_reset.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for ff_async_reset: four instances (W=25, 3, 256, 8 with non-zero
// reset value) driven from one stimulus process, checked by a queue scoreboard.

module tb_ff_async_reset;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         cnt_mode;
    logic [24:0]  d25_r, d25, q25;
    logic [2:0]   d3, q3;
    logic [255:0] d256, q256;
    logic [7:0]   d8, q8;

    assign d25 = cnt_mode ? q25 + 25'd1 : d25_r;
    assign d3  = q3 + 3'd1;

    ff_async_reset #(.W(25)) u_dut25 (.clk(clk), .rst(rst), .d(d25), .q(q25));
    ff_async_reset #(.W(3)) u_dut3 (.clk(clk), .rst(rst), .d(d3), .q(q3));
    ff_async_reset #(.W(256)) u_dut256 (.clk(clk), .rst(rst), .d(d256), .q(q256));
    ff_async_reset #(.W(8), .RESET_VAL(8'hA5)) u_dut8 (.clk(clk), .rst(rst), .d(d8), .q(q8));

    typedef struct {
        string        name;
        int           unit;
        logic [255:0] exp;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   errors = 0;
    int   checks = 0;

    // Reference model: what each register should hold according to the rules.
    logic [24:0]  m25;
    int           m3;
    logic [255:0] m256;
    logic [7:0]   m8;

    function automatic logic [255:0] actual(input int unit);
        case (unit)
            0:       return 256'(q25);
            1:       return 256'(q3);
            2:       return q256;
            default: return 256'(q8);
        endcase
    endfunction

    task automatic model_reset();
        m25  = '0;
        m3   = 0;
        m256 = '0;
        m8   = 8'hA5;
    endtask

    // One rising edge: reset dominates; otherwise every register takes its d.
    task automatic model_edge();
        if (!rst) begin
            m25  = cnt_mode ? m25 + 25'd1 : d25_r;
            m3   = (m3 + 1) % 8;
            m256 = d256;
            m8   = d8;
        end
    endtask

    task automatic push_all(input string tag);
        sb.push_back('{{tag, "_q25"}, 0, 256'(m25)});
        sb.push_back('{{tag, "_q3"}, 1, 256'(m3)});
        sb.push_back('{{tag, "_q256"}, 2, m256});
        sb.push_back('{{tag, "_q8"}, 3, 256'(m8)});
        -> chk_ev;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        push_all(tag);
    endtask

    // Monitor: drains the scoreboard whenever the stimulus marks outputs as settled.
    exp_t         e;
    logic [255:0] a;
    initial begin
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                a = actual(e.unit);
                checks++;
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        cnt_mode = 1'b0;
        d25_r    = 25'h1ABCDEF;
        d256     = '0;
        d8       = 8'h3C;
        model_reset();

        // Reset is visible before any clock edge has occurred.
        #3;
        push_all("rst_async");
        repeat (2) step("rst_hold");

        // Release with load values prepared; nothing changes until the edge.
        @(negedge clk);
        rst   = 1'b0;
        d25_r = 25'h0000123;
        for (int k = 0; k < 8; k++)
            d256[k*32 +: 32] = (k % 2 == 0) ? 32'hDEADBEEF : 32'h01234567;
        #1;
        push_all("pre_load");
        step("load");

        d256 = '1;
        step("ones");

        repeat (20) begin
            d25_r = 25'($urandom);
            for (int k = 0; k < 8; k++)
                d256[k*32 +: 32] = $urandom;
            d8 = 8'($urandom);
            step("rand");
        end

        // Bring the 25-bit register up to 0x17 under the counter loop.
        d25_r = 25'h16;
        step("pre_cnt");
        cnt_mode = 1'b1;
        step("cnt17");

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        push_all("mid_rst_async");
        repeat (3) step("mid_rst_hold");

        @(negedge clk);
        rst = 1'b0;
        d8  = 8'h3C;
        step("release1");
        step("release2");

        @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ff_async_reset.md
# ff_async_reset

Generic W-bit D-type register with asynchronous active-high reset and no enable. It is the basic state element across the ray-tracer datapath and cache miss handlers: address registers, small counters and wide line-data registers. Callers build hold, load and increment behaviour in combinational logic on `d`, so this block captures `d` on every clock edge.

## Interface
- `W`, default 1: data width in bits; must be ≥ 1. Used values include 1–4 (counters), 25 (SDRAM address) and 64–384 (cache line).
- `RESET_VAL`, default 0: value loaded into `q` on reset; W bits wide, zero-extended or truncated to W.
- `clk`  input  1: the single clock; `q` updates on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `d`  input  W: next-state value.
- `q`  output  W: registered state.

## Operation
- `rst` high forces `q` = `RESET_VAL` immediately, without waiting for a clock edge.
- `q` holds `RESET_VAL` for as long as `rst` stays high. Clock edges during reset have no effect.
- With `rst` low, each rising `clk` edge loads `q` ← `d`, covering all W bits in parallel.
- There is no enable, so the register loads on every edge. To hold, the caller drives `d` = `q`.
- `d` passes through with no arithmetic, sign handling or width conversion. The bit ordering of `d[W-1:0]` is preserved exactly in `q`. Callers may connect packed multi-dimensional arrays whose total width is W.
- The reset value is fixed at elaboration time. There is no runtime preset.
- The block uses no internal state other than the W flops and adds no combinational path from `d` to `q`.

## Timing
- Latency: 1 clock. `q` equals the `d` value sampled at the most recent rising edge.
- Reset assertion takes effect asynchronously, within the same delta or cycle that `rst` rises.
- Reset release: the first load happens on the first rising edge at which `rst` is sampled low.
- If `rst` is high at the same moment as a `clk` rising edge, reset wins and `q` = `RESET_VAL`.
- Reset asserted mid-operation discards the current contents. No partial-width updates occur.
- Output value before the first reset: undefined (X in simulation). Every system-level reset must assert `rst`.

## Test plan
1. Reset: W=25. Drive `d`=25'h1ABCDEF, pulse `rst` high between clock edges. Required: `q`=0 immediately, with no clock edge needed, and `q`=0 while `rst` stays high even with clocks running.
2. Load: W=25, `rst` low. Drive `d`=25'h0000123 before edge n. Required: `q`=25'h0000123 after edge n and not before.
3. Hold/increment loop: W=3, drive `d`=`q`+1. Run 10 edges from reset. Required sequence: 0,1,2,3,4,5,6,7,0,1,2 (wrap at 2^W).
4. Wide data: W=256. Drive `d` = alternating 32'hDEADBEEF/32'h01234567 words. Required: exact 256-bit match on `q` after one edge, then all-ones after loading all-ones.
5. Mid-operation reset: W=25, with the counter loop running at `q`=25'h17. Assert `rst` asynchronously for 3 cycles. Required: `q`=0 throughout; after release, `q`=1 on the first edge.
6. Non-zero reset value: W=8, `RESET_VAL`=8'hA5. Assert `rst`. Required: `q`=8'hA5. After release with `d`=8'h3C, `q`=8'h3C after 1 edge.
